tlb: RTL



---
 rtl/tlb_if.sv | 21 ++
 rtl/tlb.sv | 87 ++++++++
 2 files changed

// File: rtl/tlb_if.sv
// MMU <-> TLB port: combinational VPN lookup plus refill/flush strobes.
// No valid/ready pair: a lookup is answered in the cycle tlb_addr is driven, and
// tlb_update/invalid are single-cycle strobes that are always accepted at the edge.
interface tlb_if;
    logic        invalid;
    logic [26:0] tlb_addr;
    logic [43:0] tlb_rdata;
    logic        tlb_hit;
    logic [43:0] tlb_wdata;
    logic        tlb_update;

    modport master (
        output invalid, tlb_addr, tlb_wdata, tlb_update,
        input  tlb_rdata, tlb_hit
    );

    modport slave (
        input  invalid, tlb_addr, tlb_wdata, tlb_update,
        output tlb_rdata, tlb_hit
    );
endinterface

// File: rtl/tlb.sv
// Fully-associative TLB: zero-latency VPN->PPN lookup, de-duplicating refill
// with lowest-free-slot fill then round-robin eviction, and full flush.
module tlb #(
    parameter int ENTRIES = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    tlb_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [26:0]        tag_q [ENTRIES];
    logic [43:0]        ppn_q [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [ENTRIES-1:0] match;
    logic [IDX_W-1:0]   match_idx;
    logic [IDX_W-1:0]   free_idx;
    logic [43:0]        match_ppn;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;

    // Refill never creates duplicate tags, so match is at most one-hot and the
    // OR-reduction of matching PPNs selects the single hit.
    always_comb begin
        match     = '0;
        match_idx = '0;
        match_ppn = '0;
        free_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == bus.tlb_addr)) begin
                match[i]  = 1'b1;
                match_idx = IDX_W'(i);
                match_ppn = match_ppn | ppn_q[i];
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign bus.tlb_hit   = (|match) & ~bus.invalid;
    assign bus.tlb_rdata = bus.tlb_hit ? match_ppn : 44'h0;

    always_comb begin
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        wr_en    = 1'b0;
        wr_idx   = '0;
        if (bus.invalid) begin
            valid_d  = '0;
            rr_ptr_d = '0;
        end else if (bus.tlb_update) begin
            wr_en = 1'b1;
            if (|match) begin
                wr_idx = match_idx;
            end else if (!(&valid_q)) begin
                wr_idx = free_idx;
            end else begin
                wr_idx   = rr_ptr_q;
                rr_ptr_d = rr_ptr_q + 1'b1;
            end
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Tag/PPN storage carries no reset; valid_q alone decides residency.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= bus.tlb_addr;
            ppn_q[wr_idx] <= bus.tlb_wdata;
        end
    end
endmodule
